cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Round-robin arbiter for the common data bus (CDB) shared by the reservation-station result producers.
//  Producers are the lw, add and mul unit groups plus a spare port.
//  Each cycle it picks at most one pending result (tag + value) and registers it onto the CDB.
//  Reservation stations and the register-result-status table snoop the registered CDB.
//  This gives them a single, conflict-free broadcast per clock instead of blocking writes to a shared cdb reg.
// PARAMETERS
//  N_REQ   4   number of requesting producers (>=2)
//  UNIT_W  8   tag width (reservation-station unit code, matches UNIT_SIZE)
//  WORD_W  32  result value width (matches WORD_SIZE)
//  SRC_W   2   width of cdb_src; must equal clog2(N_REQ)
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active high
//  flush      in   1             drop arbitration this cycle (mispredict/abort)
//  req_valid  in   N_REQ         requester i has a result pending
//  req_tag    in   N_REQ*UNIT_W  tag of requester i, slice [i*UNIT_W +: UNIT_W]
//  req_data   in   N_REQ*WORD_W  value of requester i, slice [i*WORD_W +: WORD_W]
//  req_ready  out  N_REQ         one-hot grant; requester i result accepted this cycle
//  cdb_valid  out  1             CDB carries a broadcast this cycle
//  cdb_tag    out  UNIT_W        broadcast tag
//  cdb_data   out  WORD_W        broadcast value
//  cdb_src    out  SRC_W         index of requester that produced the broadcast
//  err_tag    out  1             sticky: a reserved tag was granted
// BEHAVIOUR
//  Reset (rst=1 at posedge) values:
//   - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_tag=0, rr pointer ptr=0.
//   - req_ready is forced to 0 while rst=1.
//   - rst overrides flush and every request.
//  Grant logic (combinational):
//   - Search starts at index ptr and proceeds ptr+1, ..., wrapping mod N_REQ.
//   - The first i with req_valid[i]=1 wins; req_ready=onehot(i).
//   - req_ready=0 when no request is valid, or when flush=1 or rst=1.
//   - At most one req_ready bit is ever high.
//  Handshake:
//   - A transfer occurs when req_valid[i] and req_ready[i] are both high at a posedge.
//   - A requester must hold valid, tag and data stable until it sees ready.
//   - A requester may present a new result in the cycle right after its transfer (back-to-back).
//  Registered output, 1-cycle latency:
//   - On a transfer from i: cdb_valid<=1, cdb_tag<=tag[i], cdb_data<=data[i], cdb_src<=i.
//   - On a transfer from i: ptr<=(i+1) mod N_REQ.
//   - With no transfer: cdb_valid<=0; tag, data and src hold their last values; ptr unchanged.
//  Fairness: any continuously valid requester is granted within N_REQ cycles.
//  Flush:
//   - No grant in the flush cycle; cdb_valid=0 the following cycle; ptr unchanged.
//   - A cdb_valid already registered before flush is still visible for its one cycle.
//  Reserved tag:
//   - 8'h7F means "register holds its value" and must never be broadcast.
//   - If granted with tag 7F, the beat is still broadcast with cdb_valid=1.
//   - In that case err_tag<=1 and stays 1 until rst.
//  No internal buffering; backpressure is expressed only by withholding req_ready.
// TESTING
//  1 Reset and idle:
//    - Stimulus: rst high for 2 cycles with all req_valid=1.
//    - Response: req_ready=0; afterwards cdb_valid=0, cdb_tag=0, cdb_data=0, err_tag=0.
//  2 Round-robin rotation:
//    - Stimulus: all 4 requesters valid and held.
//    - Tags/data: r0 80/1, r1 A0/2, r2 C0/3, r3 81/4.
//    - Response: grants in order r0,r1,r2,r3,r0.
//    - Response: the CDB shows (80,1),(A0,2),(C0,3),(81,4), each one cycle after its grant.
//  3 Wrap search:
//    - Stimulus: first get ptr=3 (grant r2 once), then assert only r1 valid.
//    - Response: r1 granted the same cycle; next cycle cdb_src=1; ptr becomes 2.
//  4 Back-to-back single source:
//    - Stimulus: r1 valid for 3 cycles with data 10,11,12.
//    - Response: cdb_valid high 3 consecutive cycles with data 10,11,12; then cdb_valid=0.
//  5 Flush:
//    - Stimulus: r0 and r2 valid, flush pulse for 1 cycle.
//    - Response: req_ready=0 in the flush cycle and cdb_valid=0 the next cycle.
//    - Response: the next cycle grants the same index that would have won before the flush.
//  6 Reserved tag:
//    - Stimulus: r3 sole requester with tag 7F, data 5.
//    - Response: CDB shows 7F/5 and err_tag rises.
//    - Response: err_tag stays 1 across later normal beats and clears only on rst.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one pending producer result per clock
// and registers it as a single broadcast that reservation stations and the status table snoop.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int UNIT_W = 8,
    parameter int WORD_W = 32,
    parameter int SRC_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*UNIT_W-1:0]   req_tag,
    input  logic [N_REQ*WORD_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      cdb_valid,
    output logic [UNIT_W-1:0]         cdb_tag,
    output logic [WORD_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src,
    output logic                      err_tag
);

    // Tag value meaning "register holds its value"; it must never appear on the bus.
    localparam logic [UNIT_W-1:0] RESERVED_TAG = UNIT_W'(8'h7F);
    localparam int                IW           = SRC_W + 1;

    logic [UNIT_W-1:0] tag_arr  [N_REQ];
    logic [WORD_W-1:0] data_arr [N_REQ];

    logic [SRC_W-1:0]  ptr_reg;
    logic [SRC_W-1:0]  ptr_next;
    logic              cdb_valid_reg;
    logic [UNIT_W-1:0] cdb_tag_reg;
    logic [WORD_W-1:0] cdb_data_reg;
    logic [SRC_W-1:0]  cdb_src_reg;
    logic              err_tag_reg;

    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    logic [IW-1:0]     idx_w;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign tag_arr[gi]   = req_tag[gi*UNIT_W +: UNIT_W];
            assign data_arr[gi]  = req_data[gi*WORD_W +: WORD_W];
            assign req_ready[gi] = grant_found && (grant_idx == SRC_W'(gi));
        end
    endgenerate

    // Search from ptr upward, wrapping modulo N_REQ; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_w       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_w = {1'b0, ptr_reg} + IW'(k);
            if (idx_w >= IW'(N_REQ))
                idx_w = idx_w - IW'(N_REQ);
            if (!grant_found && req_valid[idx_w[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_w[SRC_W-1:0];
            end
        end
        if (rst || flush)
            grant_found = 1'b0;
    end

    assign ptr_next = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_tag_reg   <= '0;
            cdb_data_reg  <= '0;
            cdb_src_reg   <= '0;
            err_tag_reg   <= 1'b0;
        end else if (grant_found) begin
            ptr_reg       <= ptr_next;
            cdb_valid_reg <= 1'b1;
            cdb_tag_reg   <= tag_arr[grant_idx];
            cdb_data_reg  <= data_arr[grant_idx];
            cdb_src_reg   <= grant_idx;
            if (tag_arr[grant_idx] == RESERVED_TAG)
                err_tag_reg <= 1'b1;
        end else begin
            cdb_valid_reg <= 1'b0;
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_tag   = cdb_tag_reg;
    assign cdb_data  = cdb_data_reg;
    assign cdb_src   = cdb_src_reg;
    assign err_tag   = err_tag_reg;

endmodule
